morra_torneo_ctrl: RTL and testbench
====================================

Name: morra_torneo_ctrl

Overview:
Tournament sequencer for the MorraCinese FSMD game core.
- Configures each game on the core by issuing the inizia cycle.
- Feeds player moves to the core through a valid/ready handshake.
- Reads back the per-manche and per-game results and tallies won games.
- Declares the tournament winner (first to WIN_TARGET games, or best tally after MAX_GAMES).
- Sits between the player-input front end and the game core.

Parameters:
WIN_TARGET, 2, game wins needed to take the tournament
MAX_GAMES, 5, hard limit on games played, so draw-heavy tournaments terminate
CNT_W, 3, width of the game tallies (must hold MAX_GAMES)

Ports:
clk  in  1  system clock; all registers update on the rising edge
rst_n  in  1  asynchronous, active-low reset
start  in  1  single-cycle request to begin a tournament
cfg_max  in  4  max-manche code for every game; sent as {primo,secondo} during inizia
mv_valid  in  1  a move pair is offered
mv_ready  out  1  the controller accepts a move pair
mv_primo  in  2  player 1 move: 01 sasso, 10 carta, 11 forbice, 00 none
mv_secondo  in  2  player 2 move, same encoding
core_primo  out  2  to game core primo
core_secondo  out  2  to game core secondo
core_inizia  out  1  to game core inizia
core_manche  in  2  from core: 00 invalid, 01 P1 wins, 10 P2 wins, 11 draw
core_partita  in  2  from core: 00 in progress, 01 P1, 10 P2, 11 draw
res_valid  out  1  one-cycle pulse when a manche result has been captured
last_manche  out  2  most recent captured core_manche value
games_p1  out  CNT_W  games won by player 1
games_p2  out  CNT_W  games won by player 2
games_draw  out  CNT_W  games drawn
busy  out  1  a tournament is in progress
done  out  1  tournament finished; held until the next start
winner  out  2  01 P1, 10 P2, 11 tie; 00 until done

Behaviour:
- Reset (asynchronous, any state): state IDLE; every output 0, including core_* (00, 00, 0), tallies, winner and done.
- Outputs are all registered, and the core drive is registered. Outside CFG and ISSUE the core sees primo = secondo = 00 with inizia = 0. The core treats that as an invalid manche with no state change.
- States:
  - IDLE: busy = 0. If start, then clear tallies and winner and go to CFG.
  - CFG (1 cycle): core_inizia = 1, core_primo = cfg_max[3:2], core_secondo = cfg_max[1:0]. Go to WAIT_MV.
  - WAIT_MV: mv_ready = 1, and only in this state. If mv_valid, capture the move and go to ISSUE.
  - ISSUE (1 cycle): core_primo/core_secondo = captured move, core_inizia = 0. Go to CHECK.
  - CHECK (1 cycle): sample core_manche/core_partita. These are the core's response to the move issued at the end of ISSUE. Set last_manche and pulse res_valid.
    - If partita = 00, go to WAIT_MV.
    - Otherwise increment the matching tally (11 increments games_draw) and go to GAME_END.
  - GAME_END (1 cycle):
    - If games_p1 = WIN_TARGET, set winner = 01. If games_p2 = WIN_TARGET, set winner = 10.
    - Else, if p1 + p2 + draw = MAX_GAMES, set winner by tally comparison (p1 > p2: 01, p2 > p1: 10, equal: 11).
    - Else go to CFG for the next game.
    - When a winner is set, go to DONE.
  - DONE: done = 1, busy = 0, winner and tallies held. If start, clear and go to CFG (done drops in the same edge).
- Latency: move accepted at edge t → driven to the core during cycle t..t+1 → res_valid high in the cycle after edge t+2.
- busy = 1 in CFG, WAIT_MV, ISSUE, CHECK and GAME_END.
- start while busy is ignored.
- Moves are forwarded unmodified, including 00. Validity (including the winner-repeat rule) is judged by the core only. last_manche = 00 changes no tally.
- Tallies saturate at 2^CNT_W − 1; this is unreachable when MAX_GAMES ≤ 2^CNT_W − 1.
- The controller does not reset the core. After a mid-game reset, the next start's CFG re-initialises it.

Test Plan:
1. Defaults, cfg_max = 0000. Two games of 01/11, 10/01, 11/10, 01/11 against a core model (each game ends at manche 4, partita = 01) → games_p1 = 2, winner = 01, done = 1, 2 CFG cycles with core_inizia = 1.
2. In WAIT_MV, move 00/11 → res_valid pulse with last_manche = 00, tallies unchanged, mv_ready = 1 again 2 cycles later.
3. Five games all ending partita = 11 → games_draw = 5, winner = 11 after the fifth GAME_END.
4. mv_valid held high from CFG onward → mv_ready only in WAIT_MV, exactly one move consumed per ISSUE, core_primo returns to 00 after each ISSUE.
5. start pulsed during WAIT_MV → ignored. rst_n low mid-ISSUE → all outputs 0 immediately (asynchronous), state IDLE. A subsequent start issues CFG with cfg_max.
6. Accept a move at edge t → core_primo/core_secondo valid only between edges t and t+1; res_valid high exactly in cycle t+2.

Source files
------------

// File: rtl/morra_torneo_ctrl.sv
// Tournament sequencer for the MorraCinese game core: configures each game, forwards
// moves, tallies game results and declares the tournament winner.
module morra_torneo_ctrl #(
    parameter int WIN_TARGET = 2,
    parameter int MAX_GAMES  = 5,
    parameter int CNT_W      = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       cfg_max,
    input  logic             mv_valid,
    output logic             mv_ready,
    input  logic [1:0]       mv_primo,
    input  logic [1:0]       mv_secondo,
    output logic [1:0]       core_primo,
    output logic [1:0]       core_secondo,
    output logic             core_inizia,
    input  logic [1:0]       core_manche,
    input  logic [1:0]       core_partita,
    output logic             res_valid,
    output logic [1:0]       last_manche,
    output logic [CNT_W-1:0] games_p1,
    output logic [CNT_W-1:0] games_p2,
    output logic [CNT_W-1:0] games_draw,
    output logic             busy,
    output logic             done,
    output logic [1:0]       winner
);

    // state    | meaning
    // IDLE     | waiting for start
    // CFG      | inizia cycle, cfg_max driven to the core
    // WAIT_MV  | mv_ready high, waiting for a move pair
    // ISSUE    | captured move driven to the core
    // CHECK    | core response sampled, res_valid pulsed next cycle
    // GAME_END | decide tournament winner or start next game
    // DONE     | result held until the next start
    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_WAIT_MV, S_ISSUE, S_CHECK, S_GAME_END, S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_SAT = '1;
    localparam logic [CNT_W-1:0] WIN_T   = CNT_W'(WIN_TARGET);
    localparam logic [CNT_W+1:0] MAX_G   = (CNT_W+2)'(MAX_GAMES);

    state_t           state_q;
    logic             mv_ready_q, core_inizia_q, res_valid_q, busy_q, done_q;
    logic [1:0]       core_primo_q, core_secondo_q, last_manche_q, winner_q;
    logic [CNT_W-1:0] games_p1_q, games_p2_q, games_draw_q;
    logic [CNT_W+1:0] games_total;

    assign games_total = {2'b00, games_p1_q} + {2'b00, games_p2_q} + {2'b00, games_draw_q};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            mv_ready_q     <= 1'b0;
            core_primo_q   <= 2'b00;
            core_secondo_q <= 2'b00;
            core_inizia_q  <= 1'b0;
            res_valid_q    <= 1'b0;
            last_manche_q  <= 2'b00;
            games_p1_q     <= '0;
            games_p2_q     <= '0;
            games_draw_q   <= '0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            winner_q       <= 2'b00;
        end else begin
            // core drive idles at 00/00/0 unless a state below overrides it
            mv_ready_q     <= 1'b0;
            core_primo_q   <= 2'b00;
            core_secondo_q <= 2'b00;
            core_inizia_q  <= 1'b0;
            res_valid_q    <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        games_p1_q     <= '0;
                        games_p2_q     <= '0;
                        games_draw_q   <= '0;
                        winner_q       <= 2'b00;
                        done_q         <= 1'b0;
                        busy_q         <= 1'b1;
                        core_inizia_q  <= 1'b1;
                        core_primo_q   <= cfg_max[3:2];
                        core_secondo_q <= cfg_max[1:0];
                        state_q        <= S_CFG;
                    end
                end
                S_CFG: begin
                    mv_ready_q <= 1'b1;
                    state_q    <= S_WAIT_MV;
                end
                S_WAIT_MV: begin
                    if (mv_valid) begin
                        core_primo_q   <= mv_primo;
                        core_secondo_q <= mv_secondo;
                        state_q        <= S_ISSUE;
                    end else begin
                        mv_ready_q <= 1'b1;
                    end
                end
                S_ISSUE: state_q <= S_CHECK;
                S_CHECK: begin
                    last_manche_q <= core_manche;
                    res_valid_q   <= 1'b1;
                    if (core_partita == 2'b00) begin
                        mv_ready_q <= 1'b1;
                        state_q    <= S_WAIT_MV;
                    end else begin
                        case (core_partita)
                            2'b01:   if (games_p1_q != CNT_SAT) games_p1_q <= games_p1_q + 1'b1;
                            2'b10:   if (games_p2_q != CNT_SAT) games_p2_q <= games_p2_q + 1'b1;
                            default: if (games_draw_q != CNT_SAT) games_draw_q <= games_draw_q + 1'b1;
                        endcase
                        state_q <= S_GAME_END;
                    end
                end
                S_GAME_END: begin
                    if (games_p1_q == WIN_T || games_p2_q == WIN_T || games_total == MAX_G) begin
                        if (games_p1_q == WIN_T)           winner_q <= 2'b01;
                        else if (games_p2_q == WIN_T)      winner_q <= 2'b10;
                        else if (games_p1_q > games_p2_q)  winner_q <= 2'b01;
                        else if (games_p2_q > games_p1_q)  winner_q <= 2'b10;
                        else                               winner_q <= 2'b11;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_DONE;
                    end else begin
                        core_inizia_q  <= 1'b1;
                        core_primo_q   <= cfg_max[3:2];
                        core_secondo_q <= cfg_max[1:0];
                        state_q        <= S_CFG;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign mv_ready     = mv_ready_q;
    assign core_primo   = core_primo_q;
    assign core_secondo = core_secondo_q;
    assign core_inizia  = core_inizia_q;
    assign res_valid    = res_valid_q;
    assign last_manche  = last_manche_q;
    assign games_p1     = games_p1_q;
    assign games_p2     = games_p2_q;
    assign games_draw   = games_draw_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign winner       = winner_q;

endmodule

// File: tb/tb_morra_torneo_ctrl.sv
// Directed bench for morra_torneo_ctrl with a small behavioural game-core model
// (every game lasts four valid manches).
module tb_morra_torneo_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] cfg_max = 4'b0000;
    logic       mv_valid = 1'b0;
    logic [1:0] mv_primo = 2'b00, mv_secondo = 2'b00;
    logic       mv_ready, core_inizia, res_valid, busy, done;
    logic [1:0] core_primo, core_secondo, last_manche, winner;
    logic [1:0] core_manche = 2'b00, core_partita = 2'b00;
    logic [2:0] games_p1, games_p2, games_draw;

    int total = 0;
    int bad = 0;
    int inizia_cnt = 0;

    morra_torneo_ctrl dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_max(cfg_max),
        .mv_valid(mv_valid), .mv_ready(mv_ready), .mv_primo(mv_primo), .mv_secondo(mv_secondo),
        .core_primo(core_primo), .core_secondo(core_secondo), .core_inizia(core_inizia),
        .core_manche(core_manche), .core_partita(core_partita),
        .res_valid(res_valid), .last_manche(last_manche),
        .games_p1(games_p1), .games_p2(games_p2), .games_draw(games_draw),
        .busy(busy), .done(done), .winner(winner)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (core_inizia === 1'b1) inizia_cnt++;

    // game core model: 01 sasso, 10 carta, 11 forbice
    function automatic logic [1:0] manche_of(input logic [1:0] p, input logic [1:0] s);
        if (p == s) return 2'b11;
        if ((p == 2'b01 && s == 2'b11) || (p == 2'b10 && s == 2'b01) || (p == 2'b11 && s == 2'b10))
            return 2'b01;
        return 2'b10;
    endfunction

    int m_cnt = 0, m_w1 = 0, m_w2 = 0;
    always @(posedge clk) begin
        logic [1:0] r;
        int nw1, nw2;
        if (core_inizia) begin
            m_cnt <= 0; m_w1 <= 0; m_w2 <= 0;
            core_manche <= 2'b00; core_partita <= 2'b00;
        end else if (core_primo != 2'b00 && core_secondo != 2'b00 && m_cnt < 4) begin
            r = manche_of(core_primo, core_secondo);
            nw1 = m_w1 + ((r == 2'b01) ? 1 : 0);
            nw2 = m_w2 + ((r == 2'b10) ? 1 : 0);
            m_w1 <= nw1; m_w2 <= nw2; m_cnt <= m_cnt + 1;
            core_manche <= r;
            if (m_cnt == 3) core_partita <= (nw1 > nw2) ? 2'b01 : (nw2 > nw1) ? 2'b10 : 2'b11;
            else            core_partita <= 2'b00;
        end else begin
            core_manche <= 2'b00; core_partita <= 2'b00;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    task automatic play_move(input logic [1:0] p, input logic [1:0] s);
        int n = 0;
        while (mv_ready !== 1'b1 && n < 40) begin step(); n++; end
        total++;
        if (mv_ready !== 1'b1) begin
            bad++; $display("FAIL wait_mv_ready got=%b want=1", mv_ready);
        end else begin
            mv_valid = 1'b1; mv_primo = p; mv_secondo = s;
            step();
            mv_valid = 1'b0; mv_primo = 2'b00; mv_secondo = 2'b00;
            n = 0;
            while (res_valid !== 1'b1 && n < 10) begin step(); n++; end
            total++;
            if (res_valid !== 1'b1) begin bad++; $display("FAIL wait_res_valid got=%b want=1", res_valid); end
        end
    endtask

    task automatic play_game(input logic [1:0] p, input logic [1:0] s);
        for (int i = 0; i < 4; i++) play_move(p, s);
    endtask

    task automatic wait_done();
        int n = 0;
        while (done !== 1'b1 && n < 20) begin step(); n++; end
        total++;
        if (done !== 1'b1) begin bad++; $display("FAIL wait_done got=%b want=1", done); end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; step(); step();
        total++;
        if ({mv_ready, core_primo, core_secondo, core_inizia, res_valid, last_manche, games_p1,
             games_p2, games_draw, busy, done, winner} !== 22'd0) begin
            bad++; $display("FAIL reset_outputs got=%b want=0", {mv_ready, core_primo, core_secondo,
                core_inizia, res_valid, last_manche, games_p1, games_p2, games_draw, busy, done, winner});
        end
        rst_n = 1'b1; step();
    endtask

    task automatic test_two_games();
        cfg_max = 4'b0000; inizia_cnt = 0;
        pulse_start();
        play_game(2'b01, 2'b11);
        total++;
        if (games_p1 !== 3'd1 || winner !== 2'b00 || done !== 1'b0) begin
            bad++; $display("FAIL game1_tally got p1=%0d w=%b d=%b want p1=1 w=00 d=0", games_p1, winner, done);
        end
        play_move(2'b01, 2'b11); play_move(2'b10, 2'b01); play_move(2'b11, 2'b10); play_move(2'b01, 2'b11);
        wait_done();
        total++;
        if (games_p1 !== 3'd2 || games_p2 !== 3'd0 || games_draw !== 3'd0) begin
            bad++; $display("FAIL two_games_tally got %0d/%0d/%0d want 2/0/0", games_p1, games_p2, games_draw);
        end
        total++;
        if (winner !== 2'b01 || busy !== 1'b0) begin
            bad++; $display("FAIL two_games_winner got w=%b busy=%b want w=01 busy=0", winner, busy);
        end
        total++;
        if (inizia_cnt !== 2) begin bad++; $display("FAIL cfg_cycles got=%0d want=2", inizia_cnt); end
    endtask

    task automatic test_invalid_move();
        int n = 0;
        pulse_start();
        total++;
        if (done !== 1'b0 || winner !== 2'b00 || games_p1 !== 3'd0 || busy !== 1'b1) begin
            bad++; $display("FAIL restart_clear got d=%b w=%b p1=%0d busy=%b want 0/00/0/1", done, winner, games_p1, busy);
        end
        while (mv_ready !== 1'b1 && n < 10) begin step(); n++; end
        mv_valid = 1'b1; mv_primo = 2'b00; mv_secondo = 2'b11;
        step();
        mv_valid = 1'b0; mv_secondo = 2'b00;
        step();
        total++;
        if (res_valid !== 1'b0 || mv_ready !== 1'b0) begin
            bad++; $display("FAIL invalid_t1 got rv=%b rdy=%b want 0/0", res_valid, mv_ready);
        end
        step();
        total++;
        if (res_valid !== 1'b1 || last_manche !== 2'b00 || mv_ready !== 1'b1) begin
            bad++; $display("FAIL invalid_t2 got rv=%b lm=%b rdy=%b want 1/00/1", res_valid, last_manche, mv_ready);
        end
        total++;
        if ({games_p1, games_p2, games_draw} !== 9'd0) begin
            bad++; $display("FAIL invalid_tally got=%b want=0", {games_p1, games_p2, games_draw});
        end
    endtask

    task automatic test_latency();
        mv_valid = 1'b1; mv_primo = 2'b01; mv_secondo = 2'b11;
        step();
        mv_valid = 1'b0; mv_primo = 2'b00; mv_secondo = 2'b00;
        total++;
        if (core_primo !== 2'b01 || core_secondo !== 2'b11 || core_inizia !== 1'b0 || res_valid !== 1'b0) begin
            bad++; $display("FAIL lat_issue got %b/%b/%b rv=%b want 01/11/0 rv=0", core_primo, core_secondo, core_inizia, res_valid);
        end
        step();
        total++;
        if (core_primo !== 2'b00 || core_secondo !== 2'b00 || res_valid !== 1'b0) begin
            bad++; $display("FAIL lat_t1 got %b/%b rv=%b want 00/00 rv=0", core_primo, core_secondo, res_valid);
        end
        step();
        total++;
        if (res_valid !== 1'b1 || last_manche !== 2'b01 || games_p1 !== 3'd0) begin
            bad++; $display("FAIL lat_t2 got rv=%b lm=%b p1=%0d want 1/01/0", res_valid, last_manche, games_p1);
        end
        step();
        total++;
        if (res_valid !== 1'b0 || mv_ready !== 1'b1) begin
            bad++; $display("FAIL lat_t3 got rv=%b rdy=%b want 0/1", res_valid, mv_ready);
        end
    endtask

    task automatic test_held_valid();
        int n_rdy = 0, n_iss = 0, n_res = 0, n_ini = 0, n_bad = 0;
        logic prev_iss = 1'b0;
        mv_valid = 1'b1; mv_primo = 2'b10; mv_secondo = 2'b01;
        for (int k = 0; k < 12; k++) begin
            if (mv_ready === 1'b1) n_rdy++;
            if (res_valid === 1'b1) n_res++;
            if (core_inizia === 1'b1) n_ini++;
            if (prev_iss && core_primo !== 2'b00) n_bad++;
            if (mv_ready === 1'b1 && core_primo !== 2'b00) n_bad++;
            prev_iss = (core_primo === 2'b10 && core_inizia === 1'b0);
            if (prev_iss) n_iss++;
            if (k == 11) mv_valid = 1'b0;
            step();
        end
        mv_primo = 2'b00; mv_secondo = 2'b00;
        total++;
        if (n_rdy != 4 || n_iss != 3 || n_res != 3 || n_ini != 1) begin
            bad++; $display("FAIL held_counts got rdy=%0d iss=%0d res=%0d ini=%0d want 4/3/3/1", n_rdy, n_iss, n_res, n_ini);
        end
        total++;
        if (n_bad != 0) begin bad++; $display("FAIL held_core_idle got=%0d want=0", n_bad); end
        total++;
        if (games_p1 !== 3'd1 || mv_ready !== 1'b1) begin
            bad++; $display("FAIL held_end got p1=%0d rdy=%b want 1/1", games_p1, mv_ready);
        end
    endtask

    task automatic test_start_ignored_reset();
        pulse_start();
        total++;
        if (busy !== 1'b1 || mv_ready !== 1'b1 || core_inizia !== 1'b0 || games_p1 !== 3'd1) begin
            bad++; $display("FAIL start_ignored got busy=%b rdy=%b ini=%b p1=%0d want 1/1/0/1", busy, mv_ready, core_inizia, games_p1);
        end
        mv_valid = 1'b1; mv_primo = 2'b01; mv_secondo = 2'b11;
        step();
        mv_valid = 1'b0; mv_primo = 2'b00; mv_secondo = 2'b00;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({mv_ready, core_primo, core_secondo, core_inizia, res_valid, last_manche, games_p1,
             games_p2, games_draw, busy, done, winner} !== 22'd0) begin
            bad++; $display("FAIL async_reset got=%b want=0", {mv_ready, core_primo, core_secondo,
                core_inizia, res_valid, last_manche, games_p1, games_p2, games_draw, busy, done, winner});
        end
        step();
        rst_n = 1'b1; cfg_max = 4'b1011;
        step();
        pulse_start();
        total++;
        if (core_inizia !== 1'b1 || core_primo !== 2'b10 || core_secondo !== 2'b11 || busy !== 1'b1) begin
            bad++; $display("FAIL cfg_drive got %b/%b/%b busy=%b want 1/10/11 busy=1", core_inizia, core_primo, core_secondo, busy);
        end
        step();
        total++;
        if (core_inizia !== 1'b0 || core_primo !== 2'b00 || mv_ready !== 1'b1) begin
            bad++; $display("FAIL cfg_exit got ini=%b cp=%b rdy=%b want 0/00/1", core_inizia, core_primo, mv_ready);
        end
    endtask

    task automatic test_draws();
        for (int g = 1; g <= 5; g++) begin
            play_game(2'b01, 2'b01);
            total++;
            if (games_draw !== 3'(g)) begin bad++; $display("FAIL draw_tally got=%0d want=%0d", games_draw, g); end
            if (g == 4) begin
                total++;
                if (winner !== 2'b00 || done !== 1'b0) begin
                    bad++; $display("FAIL draw_early got w=%b d=%b want 00/0", winner, done);
                end
            end
        end
        wait_done();
        total++;
        if (winner !== 2'b11 || games_p1 !== 3'd0 || games_p2 !== 3'd0) begin
            bad++; $display("FAIL draw_winner got w=%b p1=%0d p2=%0d want 11/0/0", winner, games_p1, games_p2);
        end
    endtask

    task automatic test_p2_wins();
        pulse_start();
        total++;
        if (done !== 1'b0 || winner !== 2'b00 || games_draw !== 3'd0) begin
            bad++; $display("FAIL p2_restart got d=%b w=%b dr=%0d want 0/00/0", done, winner, games_draw);
        end
        play_game(2'b01, 2'b10);
        play_game(2'b11, 2'b01);
        wait_done();
        total++;
        if (winner !== 2'b10 || games_p2 !== 3'd2 || games_p1 !== 3'd0) begin
            bad++; $display("FAIL p2_winner got w=%b p2=%0d p1=%0d want 10/2/0", winner, games_p2, games_p1);
        end
    endtask

    task automatic test_max_games_compare();
        pulse_start();
        play_game(2'b01, 2'b10);
        for (int g = 0; g < 4; g++) play_game(2'b11, 2'b11);
        wait_done();
        total++;
        if (winner !== 2'b10 || games_p2 !== 3'd1 || games_draw !== 3'd4) begin
            bad++; $display("FAIL max_compare got w=%b p2=%0d dr=%0d want 10/1/4", winner, games_p2, games_draw);
        end
        step(); step();
        total++;
        if (done !== 1'b1 || winner !== 2'b10 || busy !== 1'b0) begin
            bad++; $display("FAIL done_hold got d=%b w=%b busy=%b want 1/10/0", done, winner, busy);
        end
    endtask

    initial begin
        test_reset();
        test_two_games();
        test_invalid_move();
        test_latency();
        test_held_valid();
        test_start_ignored_reset();
        test_draws();
        test_p2_wins();
        test_max_games_compare();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
